instr_fetch_ctrl: RTL and testbench

- Fetch sequencer for the combinational instruction memory `instr_mem`, which maps addr to data in the same cycle.
- Owns the program counter and drives `instr_mem.addr`.
- Registers each fetched word into a one-entry valid/ready output stage toward decode.
- Handles branch/jump redirects (flush) and stops fetching on a halt instruction until redirected.

---
 rtl/instr_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a combinational instruction memory.
// Owns the PC and drives the memory word address. Each fetched word is
// registered into a one-entry valid/ready stage toward decode.
// Redirects flush the stage and reload the PC. A HALT_INSTR encoding is
// delivered normally and then stops fetch until the next redirect.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction memory (combinational read)
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,

    // Branch / jump redirect
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    // Output stage toward decode
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,

    // Status
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic       StFetch = 1'b0;
    localparam logic       StHalt  = 1'b1;

    localparam logic [31:0] PcStep = 32'(PC_STEP);

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        slot_free;
    logic        handshake;
    logic [31:0] redirect_target;

    // Low address bits of the redirect target are deliberately discarded.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign slot_free       = !out_valid_q || out_ready;
    assign handshake       = out_valid_q && out_ready;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // Word index into the memory, derived straight from the PC register.
    assign imem_addr = {2'b00, pc_q[31:2]};

    // Next-state logic: redirect outranks capture; HALT only drains the stage.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        if (redirect_valid) begin
            // Flush: a pending unaccepted instruction is dropped.
            pc_d        = redirect_target;
            out_valid_d = 1'b0;
            state_d     = StFetch;
        end else begin
            case (state_q)
                StFetch: begin
                    if (slot_free) begin
                        out_instr_d = imem_data;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + PcStep;
                        if (imem_data == HALT_INSTR) begin
                            state_d = StHalt;
                        end
                    end
                end
                StHalt: begin
                    // The halt instruction itself still drains normally.
                    if (handshake) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    // Delivered-instruction counter; a handshake counts even under redirect.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (handshake) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Control state and PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Output stage and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= 32'h0;
            out_pc_q      <= 32'h0;
            fetch_count_q <= 32'h0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = (state_q == StHalt);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a delivery scoreboard.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] HALT = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic        halt_en;
    int          n_checks;
    int          n_fail;
    logic [63:0] sb[$];

    instr_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i holds 0x1000_0000 + i, optionally word 5 = HALT.
    assign imem_data = (halt_en && imem_addr == 32'd5) ? HALT : 32'h1000_0000 + imem_addr;

    function automatic logic [31:0] word(input logic [31:0] idx);
        return (halt_en && idx == 32'd5) ? HALT : 32'h1000_0000 + idx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected delivery: {pc, instr}.
    task automatic push(input logic [31:0] pc);
        sb.push_back({pc, word(pc >> 2)});
    endtask

    // Score any handshake happening this cycle, then advance one edge.
    task automatic cycle();
        logic [63:0] e;
        if (out_valid && out_ready) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hs_pc", 64'(out_pc), 64'(e[63:32]));
                chk("hs_instr", 64'(out_instr), 64'(e[31:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        halt_en        = 1'b0;
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #12;

        // Reset state
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) push(32'(4 * i));
        for (int k = 1; k <= 9; k++) begin
            cycle();
            chk("seq_addr", 64'(imem_addr), 64'(k));
            chk("seq_out_pc", 64'(out_pc), 64'(4 * (k - 1)));
            chk("seq_valid", 64'(out_valid), 64'd1);
        end
        chk("seq_count", 64'(fetch_count), 64'd8);

        // Backpressure holds the stage stable
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(32'(4 * i));
        for (int k = 0; k < 3; k++) cycle();
        chk("bp_pre_pc", 64'(out_pc), 64'd8);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_pc", 64'(out_pc), 64'd8);
            chk("bp_instr", 64'(out_instr), 64'(32'h1000_0002));
            chk("bp_addr", 64'(imem_addr), 64'd3);
            chk("bp_count", 64'(fetch_count), 64'd2);
        end
        out_ready = 1'b1;
        push(32'd12);
        cycle();
        chk("bp_next_pc", 64'(out_pc), 64'd12);

        // Redirect flush drops the unaccepted pc=4 instruction
        do_reset();
        out_ready = 1'b1;
        push(32'd0);
        cycle();
        cycle();
        chk("rf_pending_pc", 64'(out_pc), 64'd4);
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0063;
        cycle();
        redirect_valid = 1'b0;
        chk("rf_flush_valid", 64'(out_valid), 64'd0);
        chk("rf_addr", 64'(imem_addr), 64'd24);
        out_ready = 1'b1;
        push(32'h60);
        cycle();
        chk("rf_tgt_valid", 64'(out_valid), 64'd1);
        chk("rf_tgt_pc", 64'(out_pc), 64'h60);
        chk("rf_tgt_instr", 64'(out_instr), 64'(32'h1000_0018));
        push(32'h64);
        cycle();
        chk("rf_count", 64'(fetch_count), 64'd2);

        // Halt, then resume via redirect
        do_reset();
        halt_en   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(32'(4 * i));
        for (int k = 0; k < 6; k++) cycle();
        chk("h_pc", 64'(out_pc), 64'd20);
        chk("h_instr", 64'(out_instr), 64'(HALT));
        chk("h_halted", 64'(halted), 64'd1);
        chk("h_addr", 64'(imem_addr), 64'd6);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("h_idle_valid", 64'(out_valid), 64'd0);
            chk("h_idle_halted", 64'(halted), 64'd1);
            chk("h_idle_addr", 64'(imem_addr), 64'd6);
            chk("h_idle_count", 64'(fetch_count), 64'd6);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        chk("hr_halted", 64'(halted), 64'd0);
        chk("hr_addr", 64'(imem_addr), 64'd0);
        push(32'd0);
        cycle();
        chk("hr_pc", 64'(out_pc), 64'd0);
        chk("hr_valid", 64'(out_valid), 64'd1);

        // Fetch up to the halt again, then reset asynchronously mid-halt
        for (int i = 1; i < 6; i++) push(32'(4 * i));
        for (int k = 0; k < 5; k++) cycle();
        out_ready = 1'b0;
        chk("ar_pre_halted", 64'(halted), 64'd1);
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_halted", 64'(halted), 64'd0);
        chk("ar_count", 64'(fetch_count), 64'd0);
        chk("ar_addr", 64'(imem_addr), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(32'd0);
        cycle();
        chk("ar_resume_pc", 64'(out_pc), 64'd0);
        chk("ar_resume_valid", 64'(out_valid), 64'd1);
        halt_en = 1'b0;

        // Redirect coincident with a handshake, then PC wrap
        do_reset();
        out_ready = 1'b1;
        push(32'd0);
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        chk("rh_count", 64'(fetch_count), 64'd1);
        chk("rh_valid", 64'(out_valid), 64'd0);
        chk("rh_addr", 64'(imem_addr), 64'd64);
        push(32'h100);
        cycle();
        chk("rh_tgt_pc", 64'(out_pc), 64'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        chk("wr_addr", 64'(imem_addr), 64'(32'h3FFF_FFFF));
        push(32'hFFFF_FFFC);
        cycle();
        chk("wr_pc", 64'(out_pc), 64'(32'hFFFF_FFFC));
        chk("wr_instr", 64'(out_instr), 64'(32'h4FFF_FFFF));
        chk("wr_next_addr", 64'(imem_addr), 64'd0);
        push(32'd0);
        cycle();
        chk("wr_wrap_pc", 64'(out_pc), 64'd0);
        chk("wr_count", 64'(fetch_count), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
